// File: rtl/branch_update_queue.sv
// In-order queue of fetch-group predictions that turns execute-stage branch
// resolutions into predictor update writes. Optional statistics counters: BRANCH_UPDATE_QUEUE_STATS_EN.
module branch_update_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic                     fetch_valid,
  input  logic [ADDR_W-1:0]        fetch_addr,
  input  logic [3:0]               fetch_pred,
  input  logic [3:0]               fetch_branch_mask,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     update,
  output logic                     branch_result,
  output logic [ADDR_W-1:0]        buffer_addr,
  output logic [1:0]               buffer_offset,
  output logic                     mispredict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic [15:0]              stat_resolved,
  output logic [15:0]              stat_mispred
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Lowest pending slot of an entry is the oldest unresolved branch in it.
  function automatic logic [1:0] lowest_slot(input logic [3:0] p);
    logic [1:0] s;
    if (p[0]) begin
      s = 2'd0;
    end else if (p[1]) begin
      s = 2'd1;
    end else if (p[2]) begin
      s = 2'd2;
    end else begin
      s = 2'd3;
    end
    return s;
  endfunction

  logic [ADDR_W-1:0] addr_q    [DEPTH];
  logic [ADDR_W-1:0] addr_d    [DEPTH];
  logic [3:0]        pred_q    [DEPTH];
  logic [3:0]        pred_d    [DEPTH];
  logic [3:0]        pending_q [DEPTH];
  logic [3:0]        pending_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic              update_q, update_d;
  logic              result_q, result_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [1:0]        boff_q, boff_d;
  logic              misp_q, misp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              full_s, empty_s;
  logic              resolve_ok_s, flush_s, push_req_s, push_s, drop_s, pop_s;
  logic [3:0]        head_pending_s, new_pending_s;
  logic [1:0]        slot_s;

  assign full_s         = (count_q == CW'(DEPTH));
  assign empty_s        = (count_q == {CW{1'b0}});
  assign head_pending_s = pending_q[head_q];
  assign slot_s         = lowest_slot(head_pending_s);
  assign new_pending_s  = head_pending_s & ~(4'b0001 << slot_s);
  assign resolve_ok_s   = resolve_valid & ~empty_s;
  assign flush_s        = resolve_ok_s & (resolve_taken != pred_q[head_q][slot_s]);
  assign push_req_s     = fetch_valid & ~stall & (fetch_branch_mask != 4'b0000);
  assign push_s         = push_req_s & ~full_s & ~flush_s;
  assign drop_s         = push_req_s & full_s & ~flush_s;
  assign pop_s          = resolve_ok_s & (flush_s | (new_pending_s == 4'b0000));

  // Next-state for queue storage, pointers, and the registered update outputs.
  always_comb begin
    addr_d    = addr_q;
    pred_d    = pred_q;
    pending_d = pending_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    update_d  = resolve_ok_s;
    result_d  = resolve_ok_s & resolve_taken;
    baddr_d   = {ADDR_W{1'b0}};
    boff_d    = 2'd0;
    misp_d    = flush_s;
    ovf_d     = ovf_q | drop_s;
    unf_d     = unf_q | (resolve_valid & empty_s);

    if (resolve_ok_s) begin
      baddr_d = addr_q[head_q];
      boff_d  = slot_s;
      pending_d[head_q] = flush_s ? 4'b0000 : new_pending_s;
    end else begin
      baddr_d = {ADDR_W{1'b0}};
    end

    if (push_s) begin
      addr_d[tail_q]    = fetch_addr;
      pred_d[tail_q]    = fetch_pred;
      pending_d[tail_q] = fetch_branch_mask;
      tail_d            = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end

    // A mispredict squashes everything younger, so the queue collapses to empty.
    if (flush_s) begin
      head_d  = tail_q;
      count_d = {CW{1'b0}};
    end else begin
      head_d  = pop_s ? head_q + PW'(1) : head_q;
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]    <= {ADDR_W{1'b0}};
        pred_q[i]    <= 4'b0000;
        pending_q[i] <= 4'b0000;
      end
      head_q   <= {PW{1'b0}};
      tail_q   <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      update_q <= 1'b0;
      result_q <= 1'b0;
      baddr_q  <= {ADDR_W{1'b0}};
      boff_q   <= 2'd0;
      misp_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      pred_q    <= pred_d;
      pending_q <= pending_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      update_q  <= update_d;
      result_q  <= result_d;
      baddr_q   <= baddr_d;
      boff_q    <= boff_d;
      misp_q    <= misp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign update        = update_q;
  assign branch_result = result_q;
  assign buffer_addr   = baddr_q;
  assign buffer_offset = boff_q;
  assign mispredict    = misp_q;
  assign full          = full_s;
  assign empty         = empty_s;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
  logic [15:0] stat_res_q, stat_res_d;
  logic [15:0] stat_mis_q, stat_mis_d;

  // Saturating counters driven by the registered output pulses.
  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (update_q && (stat_res_q != 16'hFFFF)) begin
      stat_res_d = stat_res_q + 16'd1;
    end else begin
      stat_res_d = stat_res_q;
    end
    if (misp_q && (stat_mis_q != 16'hFFFF)) begin
      stat_mis_d = stat_mis_q + 16'd1;
    end else begin
      stat_mis_d = stat_mis_q;
    end
  end

  // Statistics register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_res_q <= 16'h0000;
      stat_mis_q <= 16'h0000;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;
`else
  assign stat_resolved = 16'h0000;
  assign stat_mispred  = 16'h0000;
`endif

endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- Feeds the branch prediction buffer's update port.
- Records each fetch group's predictions as they issue (in program order), then consumes in-order branch resolutions from execute.
- For each resolution, drives one update/branch_result/buffer_addr/buffer_offset write to the predictor.
- Flags mispredicts and discards wrong-path entries.

Parameters:
- DEPTH, 4, number of fetch-group entries held; power of two, at least 2.
- ADDR_W, 2, width of predictor line address.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- stall  in  1  fetch stall, same signal the predictor sees
- fetch_valid  in  1  fetch group presented this cycle
- fetch_addr  in  ADDR_W  predictor line of the group
- fetch_pred  in  4  prediction bits returned for the group
- fetch_branch_mask  in  4  bit k set = slot k holds a branch
- resolve_valid  in  1  oldest outstanding branch resolved
- resolve_taken  in  1  actual outcome of that branch
- update  out  1  predictor update strobe
- branch_result  out  1  outcome to train with
- buffer_addr  out  ADDR_W  line to train
- buffer_offset  out  2  slot/bank to train
- mispredict  out  1  resolved outcome differed from prediction
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  log2(DEPTH)+1  entries held
- overflow  out  1  sticky: push dropped because full
- underflow  out  1  sticky: resolve seen while empty
- stat_resolved  out  16  resolved-branch count (optional feature)
- stat_mispred  out  16  mispredict count (optional feature)

Behaviour:
- Reset (reset_n low at posedge): all outputs 0, empty=1, queue cleared; overrides every other input that cycle.
- Entry fields: addr, pred[3:0], pending[3:0]. pending is loaded from fetch_branch_mask.
- Push condition: fetch_valid & !stall & (fetch_branch_mask != 0) & !full & !flush. full is the registered value; no bypass when a pop happens the same cycle.
- Mask of 0 is never pushed and does not set overflow.
- Full-drop: push condition true except full=1 -> group dropped, overflow set.
- Head slot: the lowest set bit of the head entry's pending.
- Resolve with queue non-empty (registered count) consumes the head slot k. Next cycle:
  - update=1, branch_result=resolve_taken, buffer_addr=head.addr, buffer_offset=k;
  - mispredict=(resolve_taken != head.pred[k]).
- Latency: exactly 1 cycle. update, mispredict and the other outputs are single-cycle pulses/values; they are 0 and hold 0 otherwise.
- After a resolve, bit k of pending is cleared. When pending becomes 0, the head is popped.
- Mispredict flush, same edge as the consuming resolve:
  - head entry popped regardless of remaining pending bits;
  - all younger entries discarded; count becomes 0;
  - any push that cycle is dropped without setting overflow (flush=1 is the combinational mispredict-now term).
- Resolve while empty: ignored, no update, underflow set. Push and resolve in the same cycle with empty=1 counts as resolve while empty.
- Simultaneous non-flushing push and pop: both occur; count unchanged.
- Pointers wrap modulo DEPTH. count saturates at neither bound; it is guarded by full/empty.
- overflow and underflow clear only on reset.

Optional Feature:
- Macro: BRANCH_UPDATE_QUEUE_STATS_EN.
- Defined:
  - stat_resolved increments on every update pulse;
  - stat_mispred increments on every mispredict pulse;
  - both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports tied to 0 and no counter registers are synthesised. Core behaviour is identical either way.

Test Plan:
- Single branch, correct: push addr=2, pred=4'b0100, mask=4'b0100; resolve taken=1 -> next cycle update=1, buffer_addr=2, buffer_offset=2, branch_result=1, mispredict=0; empty=1 after.
- Multi-slot ordering: push addr=1, mask=4'b1010, pred=4'b0000; two resolves taken=0 -> offsets 1 then 3, mispredict=0 both, one pop after the second.
- Mispredict flush: push 3 groups (mask 4'b0001 each, pred 0); resolve taken=1 -> update with mispredict=1, count=0, a push in that cycle dropped, overflow=0.
- Full: DEPTH+1 pushes with no resolves -> full=1, count=DEPTH, overflow=1, last group absent (drain verifies the first DEPTH addresses in order).
- Underflow, stall, mask 0: resolve while empty -> no update, underflow=1; push with stall=1 or mask=0 -> count unchanged.
- Reset mid-operation: reset_n=0 with 2 entries and a resolve pending -> next cycle count=0, update=0, stickies=0; with the macro defined, stats=0.
